universal_shift_reg: RTL and testbench
======================================

// Module: universal_shift_reg
// PURPOSE
//   Parametrised universal shift register: DEPTH stages of WIDTH bits each.
//   Supports serial-in/serial-out, serial-in/parallel-out, parallel-in/serial-out
//   and parallel-in/parallel-out, in both directions, with rotate and clear.
//   A shift counter and a frame_done pulse mark completion of a DEPTH-shift frame.
//   Serves as the generic serialiser/deserialiser/delay line for datapath blocks.
// PARAMETERS
//   WIDTH  1  bits per stage (lane width); legal range >= 1
//   DEPTH  8  number of stages; legal range >= 1
//   CW     $clog2(DEPTH+1)  localparam: counter width
// PORTS
//   clk         in   1            system clock; all state updates on posedge
//   rst         in   1            synchronous reset, active-high
//   en          in   1            clock enable; 0 = all state held
//   mode        in   3            operation select (see BEHAVIOUR)
//   si_r        in   WIDTH        serial in, enters stage DEPTH-1 on right shift
//   si_l        in   WIDTH        serial in, enters stage 0 on left shift
//   pi          in   WIDTH*DEPTH  parallel load data; stage k = pi[k*WIDTH +: WIDTH]
//   so_r        out  WIDTH        serial out, = stage 0
//   so_l        out  WIDTH        serial out, = stage DEPTH-1
//   po          out  WIDTH*DEPTH  parallel out; po[k*WIDTH +: WIDTH] = stage k
//   cnt         out  CW           shifts since last load/clear, saturates at DEPTH
//   frame_done  out  1            1-cycle pulse when cnt reaches DEPTH
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-high (rst).
//   - rst=1 at posedge: all stages, cnt, frame_done <= 0. Overrides en and mode.
//   - All outputs are direct register outputs; no combinational input->output path.
//   - en=0: stages and cnt hold; frame_done <= 0.
//   - en=1, mode decode (at posedge):
//       000 HOLD   stages hold, cnt holds
//       001 SHR    stage k <= stage k+1; stage DEPTH-1 <= si_r
//       010 SHL    stage k <= stage k-1; stage 0 <= si_l
//       011 ROR    as SHR but stage DEPTH-1 <= old stage 0
//       100 ROL    as SHL but stage 0 <= old stage DEPTH-1
//       101 LOAD   stages <= pi; cnt <= 0
//       110 CLEAR  stages <= 0; cnt <= 0
//       111 HOLD   reserved, behaves as 000
//   - cnt: SHR/SHL/ROR/ROL increment cnt by 1, saturating at DEPTH (no wrap).
//   - frame_done <= 1 exactly on the edge where cnt goes DEPTH-1 -> DEPTH; else 0.
//     Further shifts at saturation produce no further pulse until LOAD/CLEAR.
//   - Latency: si_r value applied with SHR appears on so_l after 1 edge and on
//     so_r after DEPTH edges; LOAD data visible on po/so_r/so_l after 1 edge.
//   - DEPTH=1: SHR/SHL replace the single stage with si_r/si_l; ROR/ROL hold
//     data; cnt is 1 bit; frame_done pulses on the first shift after LOAD/CLEAR.
//   - Mode changes take effect on the next edge; no state is kept between modes
//     other than stages and cnt (e.g. SHR then SHL reverses data correctly).
//   - rst asserted mid-frame: state zeroed on that edge, frame_done not pulsed.
// TESTING  (WIDTH=1, DEPTH=8 unless noted)
//   1 rst=1 with en=1, mode=LOAD, pi=8'hFF -> po=0, cnt=0, frame_done=0 after edge.
//   2 LOAD pi=8'hA5, then 8x SHR with si_r=0 -> so_r sequence 1,0,1,0,0,1,0,1;
//     po=0 after 8th; cnt=8; frame_done high only on 8th edge.
//   3 SISO delay: SHR streaming si_r=1,1,0,1,... -> so_r reproduces input 8 cycles
//     later; 9th+ shifts keep cnt=8, no second frame_done.
//   4 LOAD 8'h81, 3x ROL -> po=8'h0C; 5 more ROL -> po=8'h81, frame_done on 8th.
//   5 LOAD 8'h3C, SHL x2 with en toggling 1,0,1 (si_l=1) -> po=8'hF3 after 2
//     enabled edges, cnt=2; mode=111 next edge -> po, cnt unchanged.
//   6 WIDTH=4, DEPTH=1: LOAD 4'h9, SHR si_r=4'h6 -> so_r=so_l=4'h6, cnt=1,
//     frame_done=1; then CLEAR -> po=0, cnt=0; rst mid-shift -> all 0.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Universal shift register: DEPTH stages of WIDTH bits with shift, rotate,
// parallel load and clear, plus a saturating shift counter and frame pulse.
//
// Ports:
//   clk        - system clock, all state updates on posedge
//   rst        - synchronous active-high reset, overrides en and mode
//   en         - clock enable; 0 holds stages and cnt, clears frame_done
//   mode       - 000/111 hold, 001 SHR, 010 SHL, 011 ROR, 100 ROL,
//                101 LOAD, 110 CLEAR
//   si_r       - serial in, enters stage DEPTH-1 on right shift
//   si_l       - serial in, enters stage 0 on left shift
//   pi         - parallel load data, stage k = pi[k*WIDTH +: WIDTH]
//   so_r       - serial out, stage 0
//   so_l       - serial out, stage DEPTH-1
//   po         - parallel out, po[k*WIDTH +: WIDTH] = stage k
//   cnt        - shifts since last load/clear, saturates at DEPTH
//   frame_done - one-cycle pulse when cnt reaches DEPTH
module universal_shift_reg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [2:0]             mode,
    input  logic [WIDTH-1:0]       si_r,
    input  logic [WIDTH-1:0]       si_l,
    input  logic [WIDTH*DEPTH-1:0] pi,
    output logic [WIDTH-1:0]       so_r,
    output logic [WIDTH-1:0]       so_l,
    output logic [WIDTH*DEPTH-1:0] po,
    output logic [CW-1:0]          cnt,
    output logic                   frame_done
);

    localparam int N  = WIDTH * DEPTH;
    localparam int NX = WIDTH * (DEPTH + 1);

    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHR   = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_ROR   = 3'b011;
    localparam logic [2:0] M_ROL   = 3'b100;
    localparam logic [2:0] M_LOAD  = 3'b101;
    localparam logic [2:0] M_CLEAR = 3'b110;

    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    logic [N-1:0]  q;
    logic [N-1:0]  q_nxt;
    logic          shift;
    logic          zero_cnt;

    // Extended vectors (one extra lane) make the shift/rotate expressions
    // valid for every DEPTH, including DEPTH=1 where there is no k+1 stage.
    logic [NX-1:0] ext_shr;
    logic [NX-1:0] ext_shl;
    logic [NX-1:0] ext_ror;
    logic [NX-1:0] ext_rol;

    always_comb begin
        ext_shr  = {si_r, q} >> WIDTH;
        ext_shl  = {q, si_l};
        ext_ror  = {q[WIDTH-1:0], q} >> WIDTH;
        ext_rol  = {q, q[N-1 -: WIDTH]};
        q_nxt    = q;
        shift    = 1'b0;
        zero_cnt = 1'b0;
        case (mode)
            M_SHR: begin
                q_nxt = ext_shr[N-1:0];
                shift = 1'b1;
            end
            M_SHL: begin
                q_nxt = ext_shl[N-1:0];
                shift = 1'b1;
            end
            M_ROR: begin
                q_nxt = ext_ror[N-1:0];
                shift = 1'b1;
            end
            M_ROL: begin
                q_nxt = ext_rol[N-1:0];
                shift = 1'b1;
            end
            M_LOAD: begin
                q_nxt    = pi;
                zero_cnt = 1'b1;
            end
            M_CLEAR: begin
                q_nxt    = '0;
                zero_cnt = 1'b1;
            end
            M_HOLD: q_nxt = q;
            default: q_nxt = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else if (!en) begin
            frame_done <= 1'b0;
        end else begin
            q <= q_nxt;
            if (zero_cnt) begin
                cnt <= '0;
            end else if (shift && cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            // Pulse only on the DEPTH-1 -> DEPTH transition; once saturated
            // cnt no longer equals CNT_LAST so no repeat pulse occurs.
            frame_done <= shift && (cnt == CNT_LAST);
        end
    end

    assign po   = q;
    assign so_r = q[WIDTH-1:0];
    assign so_l = q[N-1 -: WIDTH];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg.
// Two instances: WIDTH=1/DEPTH=8 and WIDTH=4/DEPTH=1.
module tb_universal_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] mode;

    logic       si_r8, si_l8;
    logic [7:0] pi8;
    logic       so_r8, so_l8;
    logic [7:0] po8;
    logic [3:0] cnt8;
    logic       fd8;

    logic [3:0] si_r1, si_l1;
    logic [3:0] pi1;
    logic [3:0] so_r1, so_l1;
    logic [3:0] po1;
    logic       cnt1;
    logic       fd1;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] HOLD  = 3'b000;
    localparam logic [2:0] SHR   = 3'b001;
    localparam logic [2:0] SHL   = 3'b010;
    localparam logic [2:0] ROR   = 3'b011;
    localparam logic [2:0] ROL   = 3'b100;
    localparam logic [2:0] LOAD  = 3'b101;
    localparam logic [2:0] CLEAR = 3'b110;
    localparam logic [2:0] RSVD  = 3'b111;

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(1), .DEPTH(8)) u8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .si_r(si_r8), .si_l(si_l8), .pi(pi8),
        .so_r(so_r8), .so_l(so_l8), .po(po8),
        .cnt(cnt8), .frame_done(fd8)
    );

    universal_shift_reg #(.WIDTH(4), .DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode),
        .si_r(si_r1), .si_l(si_l1), .pi(pi1),
        .so_r(so_r1), .so_l(so_l1), .po(po1),
        .cnt(cnt1), .frame_done(fd1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  a5;
    logic [15:0] pat;

    initial begin
        rst = 1'b0; en = 1'b0; mode = HOLD;
        si_r8 = 1'b0; si_l8 = 1'b0; pi8 = 8'h00;
        si_r1 = 4'h0; si_l1 = 4'h0; pi1 = 4'h0;
        #2;

        // 1: reset overrides en/LOAD
        rst = 1'b1; en = 1'b1; mode = LOAD; pi8 = 8'hFF; pi1 = 4'hF;
        step();
        chk("rst_po", 32'(po8), 32'h00);
        chk("rst_cnt", 32'(cnt8), 32'd0);
        chk("rst_fd", 32'(fd8), 32'd0);
        rst = 1'b0;

        // 2: LOAD A5, 8x SHR with si_r=0
        a5 = 8'hA5;
        mode = LOAD; pi8 = a5;
        step();
        chk("load_po", 32'(po8), 32'hA5);
        chk("load_cnt", 32'(cnt8), 32'd0);
        mode = SHR; si_r8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("shr_so_r%0d", i), 32'(so_r8), 32'(a5[i]));
            step();
            chk($sformatf("shr_fd%0d", i), 32'(fd8), 32'(i == 7));
        end
        chk("shr_po", 32'(po8), 32'h00);
        chk("shr_cnt", 32'(cnt8), 32'd8);

        // 3: SISO delay line, saturation without second pulse
        mode = CLEAR;
        step();
        chk("clr_cnt", 32'(cnt8), 32'd0);
        pat = 16'b1011_0010_1110_1011;
        mode = SHR;
        for (int i = 0; i < 16; i++) begin
            si_r8 = pat[i];
            step();
            chk($sformatf("siso_so_l%0d", i), 32'(so_l8), 32'(pat[i]));
            if (i >= 7)
                chk($sformatf("siso_so_r%0d", i), 32'(so_r8),
                    32'(pat[i-7]));
            chk($sformatf("siso_fd%0d", i), 32'(fd8), 32'(i == 7));
            chk($sformatf("siso_cnt%0d", i), 32'(cnt8),
                32'((i + 1 > 8) ? 8 : i + 1));
        end

        // 4: LOAD 81, rotate left
        mode = LOAD; pi8 = 8'h81;
        step();
        mode = ROL;
        step(); step(); step();
        chk("rol3_po", 32'(po8), 32'h0C);
        chk("rol3_cnt", 32'(cnt8), 32'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rol_fd%0d", i), 32'(fd8), 32'(i == 4));
        end
        chk("rol8_po", 32'(po8), 32'h81);

        // ROR through a full frame returns data too
        mode = ROR;
        step();
        chk("ror_po", 32'(po8), 32'hC0);
        chk("ror_sat_cnt", 32'(cnt8), 32'd8);

        // 5: SHL with en gating, then reserved mode holds
        mode = LOAD; pi8 = 8'h3C;
        step();
        mode = SHL; si_l8 = 1'b1;
        step();
        chk("shl1_po", 32'(po8), 32'h79);
        en = 1'b0;
        step();
        chk("en0_po", 32'(po8), 32'h79);
        chk("en0_cnt", 32'(cnt8), 32'd1);
        en = 1'b1;
        step();
        chk("shl2_po", 32'(po8), 32'hF3);
        chk("shl2_cnt", 32'(cnt8), 32'd2);
        mode = RSVD;
        step();
        chk("rsvd_po", 32'(po8), 32'hF3);
        chk("rsvd_cnt", 32'(cnt8), 32'd2);
        mode = HOLD;
        step();
        chk("hold_po", 32'(po8), 32'hF3);

        // SHR then SHL reverses data
        mode = SHR; si_r8 = 1'b0;
        step();
        chk("rev_shr_po", 32'(po8), 32'h79);
        mode = SHL; si_l8 = 1'b1;
        step();
        chk("rev_shl_po", 32'(po8), 32'hF3);

        // rst mid-frame at cnt=7: zeroed, no pulse
        mode = CLEAR;
        step();
        mode = SHR; si_r8 = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("pre_rst_cnt", 32'(cnt8), 32'd7);
        rst = 1'b1;
        step();
        chk("midrst_fd", 32'(fd8), 32'd0);
        chk("midrst_cnt", 32'(cnt8), 32'd0);
        chk("midrst_po", 32'(po8), 32'h00);
        rst = 1'b0;

        // 6: WIDTH=4, DEPTH=1
        mode = LOAD; pi1 = 4'h9;
        step();
        chk("d1_load_po", 32'(po1), 32'h9);
        mode = SHR; si_r1 = 4'h6;
        step();
        chk("d1_so_r", 32'(so_r1), 32'h6);
        chk("d1_so_l", 32'(so_l1), 32'h6);
        chk("d1_cnt", 32'(cnt1), 32'd1);
        chk("d1_fd", 32'(fd1), 32'd1);
        mode = ROR;
        step();
        chk("d1_ror_po", 32'(po1), 32'h6);
        chk("d1_ror_fd", 32'(fd1), 32'd0);
        mode = CLEAR;
        step();
        chk("d1_clr_po", 32'(po1), 32'h0);
        chk("d1_clr_cnt", 32'(cnt1), 32'd0);
        mode = SHL; si_l1 = 4'hA;
        step();
        chk("d1_shl_po", 32'(po1), 32'hA);
        chk("d1_shl_fd", 32'(fd1), 32'd1);
        rst = 1'b1; mode = SHR; si_r1 = 4'h5;
        step();
        chk("d1_rst_po", 32'(po1), 32'h0);
        chk("d1_rst_cnt", 32'(cnt1), 32'd0);
        chk("d1_rst_fd", 32'(fd1), 32'd0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
